// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell (two half adders) sequenced over WIDTH cycles.
// Optional signed-overflow flag is built only when SERIAL_ADD_OVF_EN is defined; otherwise ovf is tied to 0.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshake: start is sampled only in IDLE or DONE (an accept); busy is high for the
  // WIDTH RUN cycles that follow; done pulses for exactly one cycle with sum/cout valid,
  // and a start seen in that DONE cycle is accepted back-to-back. Starts during RUN are dropped.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r, msb_ins;
  logic [CW-1:0]    cnt;
  logic             carry, cout_r;
  logic             hs1, hc1, hc2, s_bit, c_bit;
  logic             accept, last_bit;

  // Two cascaded half adders form the shared full-adder cell.
  always_comb begin
    hs1   = a_sh[0] ^ b_sh[0];
    hc1   = a_sh[0] & b_sh[0];
    s_bit = hs1 ^ carry;
    hc2   = hs1 & carry;
    c_bit = hc1 | hc2;
  end

  always_comb begin
    msb_ins            = '0;
    msb_ins[WIDTH-1]   = s_bit;
  end

  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_bit = (state == S_RUN) && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN:   if (last_bit) state_nx = S_DONE;
      S_DONE:  state_nx = accept ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      sum_r  <= '0;
      carry  <= cin;
      cnt    <= '0;
      cout_r <= 1'b0;
    end else if (state == S_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_r  <= (sum_r >> 1) | msb_ins;
      carry  <= c_bit;
      cnt    <= cnt + CW'(1);
      if (last_bit) cout_r <= c_bit;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_r;

  // On the last bit, carry still holds the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst || accept) ovf_r <= 1'b0;
    else if (last_bit) ovf_r <= carry ^ c_bit;
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule
